// File: rtl/slave_regfile_if.sv
//==============================================================================
// slave_regfile_if : decoder/forwarder bus for the slave register file
// Revision: 1.0
//==============================================================================
`default_nettype none

interface slave_regfile_if #(
   parameter int WIDTH    = 12,
   parameter int AW       = 5,
   parameter int RD_PORTS = 2
);
   logic                       write;
   logic [AW-1:0]              write_addr;
   logic [WIDTH-1:0]           write_node;
   logic [RD_PORTS-1:0]        read_en;
   logic [RD_PORTS*AW-1:0]     read_addr;
   logic [RD_PORTS*WIDTH-1:0]  read_node;
   logic [RD_PORTS-1:0]        read_valid;
   logic                       clear;
   logic                       busy;

   modport master (
      output write, write_addr, write_node, read_en, read_addr, clear,
      input  read_node, read_valid, busy
   );

   modport slave (
      input  write, write_addr, write_node, read_en, read_addr, clear,
      output read_node, read_valid, busy
   );
endinterface

`default_nettype wire

// File: rtl/slave_regfile.sv
//==============================================================================
// slave_regfile : multi-port register file with per-entry valid and bulk clear
// Revision: 1.0
//==============================================================================
`default_nettype none

module slave_regfile #(
   parameter int WIDTH    = 12,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int RD_PORTS = 2
) (
   input  logic             clk,
   input  logic             reset,
   slave_regfile_if.slave   bus
);

   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                     state_q;
   logic [AW-1:0]              ptr_q;
   logic                       busy_q;
   logic [WIDTH-1:0]           mem_q [DEPTH];
   logic [DEPTH-1:0]           valid_q;
   logic [RD_PORTS*WIDTH-1:0]  read_node_q;
   logic [RD_PORTS-1:0]        read_valid_q;

   logic                       wr_ok;
   logic [RD_PORTS*WIDTH-1:0]  rd_node_d;
   logic [RD_PORTS-1:0]        rd_valid_d;

   assign wr_ok = bus.write && (state_q == ST_IDLE) &&
                  ({1'b0, bus.write_addr} < C_DEPTH);

   // Per-port lookup; a same-cycle write to the addressed entry is forwarded.
   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [AW-1:0] addr;
      logic          rd_ok;
      logic          bypass;

      assign addr   = bus.read_addr[p*AW +: AW];
      assign rd_ok  = (state_q == ST_IDLE) && ({1'b0, addr} < C_DEPTH);
      assign bypass = wr_ok && (addr == bus.write_addr);

      assign rd_node_d[p*WIDTH +: WIDTH] = !rd_ok ? '0 :
                                           bypass ? bus.write_node : mem_q[addr];
      assign rd_valid_d[p]               = rd_ok && (bypass || valid_q[addr]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         busy_q       <= 1'b0;
         valid_q      <= '0;
         read_node_q  <= '0;
         read_valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int p = 0; p < RD_PORTS; p++) begin
            if (bus.read_en[p]) begin
               read_node_q[p*WIDTH +: WIDTH] <= rd_node_d[p*WIDTH +: WIDTH];
               read_valid_q[p]               <= rd_valid_d[p];
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (wr_ok) begin
                  mem_q[bus.write_addr]   <= bus.write_node;
                  valid_q[bus.write_addr] <= 1'b1;
               end
               if (bus.clear) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               mem_q[ptr_q]   <= '0;
               valid_q[ptr_q] <= 1'b0;
               if (ptr_q == C_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.read_node  = read_node_q;
   assign bus.read_valid = read_valid_q;
   assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_slave_regfile.sv
//==============================================================================
// tb_slave_regfile : randomized and directed checks against a behavioural model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_slave_regfile;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   slave_regfile_if #(.WIDTH(12), .AW(5), .RD_PORTS(2)) ifa ();
   slave_regfile_if #(.WIDTH(12), .AW(5), .RD_PORTS(2)) ifb ();

   slave_regfile #(.WIDTH(12), .DEPTH(32), .AW(5), .RD_PORTS(2)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   slave_regfile #(.WIDTH(12), .DEPTH(20), .AW(5), .RD_PORTS(2)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   logic [23:0] obs_node [2];
   logic [1:0]  obs_val  [2];
   logic        obs_busy [2];
   assign obs_node[0] = ifa.read_node;
   assign obs_node[1] = ifb.read_node;
   assign obs_val[0]  = ifa.read_valid;
   assign obs_val[1]  = ifb.read_valid;
   assign obs_busy[0] = ifa.busy;
   assign obs_busy[1] = ifb.busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: contents, valid flags, a countdown of entries left to sweep
   logic [11:0] m_mem  [2][32];
   bit          m_val  [2][32];
   int          m_left [2];
   int          m_idx  [2];
   logic [11:0] e_node [2][2];
   logic        e_val  [2][2];
   logic        e_busy [2];

   task automatic model_step(input int d, input int depth, input logic rst_n,
                             input logic wr, input logic [4:0] wa, input logic [11:0] wd,
                             input logic [1:0] ren, input logic [9:0] ra, input logic clr);
      bit busy_now;
      int a;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[d][i] = '0;
            m_val[d][i] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            e_node[d][p] = '0;
            e_val[d][p]  = 1'b0;
         end
         m_left[d] = 0;
         m_idx[d]  = 0;
         e_busy[d] = 1'b0;
         return;
      end
      busy_now = (m_left[d] > 0);
      for (int p = 0; p < 2; p++) begin
         if (ren[p]) begin
            a = int'(ra[p*5 +: 5]);
            if (busy_now || a >= depth) begin
               e_node[d][p] = '0;
               e_val[d][p]  = 1'b0;
            end else if (wr && a == int'(wa)) begin
               e_node[d][p] = wd;
               e_val[d][p]  = 1'b1;
            end else begin
               e_node[d][p] = m_mem[d][a];
               e_val[d][p]  = m_val[d][a];
            end
         end
      end
      if (busy_now) begin
         m_mem[d][m_idx[d]] = '0;
         m_val[d][m_idx[d]] = 1'b0;
         m_idx[d]++;
         m_left[d]--;
      end else begin
         if (wr && int'(wa) < depth) begin
            m_mem[d][wa] = wd;
            m_val[d][wa] = 1'b1;
         end
         if (clr) begin
            m_left[d] = depth;
            m_idx[d]  = 0;
         end
      end
      e_busy[d] = (m_left[d] > 0);
   endtask

   task automatic cycle();
      model_step(0, 32, reset, ifa.write, ifa.write_addr, ifa.write_node,
                 ifa.read_en, ifa.read_addr, ifa.clear);
      model_step(1, 20, reset, ifb.write, ifb.write_addr, ifb.write_node,
                 ifb.read_en, ifb.read_addr, ifb.clear);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ifa.write = 1'b0; ifa.write_addr = '0; ifa.write_node = '0;
      ifa.read_en = '0; ifa.read_addr = '0; ifa.clear = 1'b0;
      ifb.write = 1'b0; ifb.write_addr = '0; ifb.write_node = '0;
      ifb.read_en = '0; ifb.read_addr = '0; ifb.clear = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      ifa.write = 1'b1; ifa.write_addr = 5'd3; ifa.write_node = 12'hABC;
      cycle();
      cycle();
      reset = 1'b1;
      ifa.write = 1'b0;
      ifa.read_en = 2'b01; ifa.read_addr = {5'd0, 5'd3};
      cycle();
      n_checks++;
      if (obs_node[0][11:0] !== 12'h000 || obs_val[0][0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_read: got node=%h valid=%b, expected node=000 valid=0",
                  obs_node[0][11:0], obs_val[0][0]);
      end
      n_checks++;
      if (obs_busy[0] !== 1'b0 || obs_busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got a=%b b=%b, expected 0", obs_busy[0], obs_busy[1]);
      end
      idle_inputs();
   endtask

   task automatic test_write_read();
      idle_inputs();
      ifa.write = 1'b1; ifa.write_addr = 5'd7; ifa.write_node = 12'h5A5;
      cycle();
      ifa.write = 1'b0;
      ifa.read_en = 2'b11; ifa.read_addr = {5'd7, 5'd7};
      cycle();
      for (int p = 0; p < 2; p++) begin
         n_checks++;
         if (obs_node[0][p*12 +: 12] !== 12'h5A5 || obs_val[0][p] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read p%0d: got node=%h valid=%b, expected 5a5/1",
                     p, obs_node[0][p*12 +: 12], obs_val[0][p]);
         end
      end
      idle_inputs();
      ifb.write = 1'b1; ifb.write_addr = 5'd25; ifb.write_node = 12'h3C3;
      cycle();
      ifb.write_addr = 5'd19; ifb.write_node = 12'h777;
      cycle();
      ifb.write = 1'b0;
      ifb.read_en = 2'b11; ifb.read_addr = {5'd19, 5'd25};
      cycle();
      n_checks++;
      if (obs_node[1][11:0] !== 12'h000 || obs_val[1][0] !== 1'b0) begin
         n_fail++;
         $display("FAIL out_of_range: got node=%h valid=%b, expected 000/0",
                  obs_node[1][11:0], obs_val[1][0]);
      end
      n_checks++;
      if (obs_node[1][23:12] !== 12'h777 || obs_val[1][1] !== 1'b1) begin
         n_fail++;
         $display("FAIL last_entry: got node=%h valid=%b, expected 777/1",
                  obs_node[1][23:12], obs_val[1][1]);
      end
      idle_inputs();
   endtask

   task automatic test_bypass();
      idle_inputs();
      ifa.write = 1'b1; ifa.write_addr = 5'd4; ifa.write_node = 12'h123;
      ifa.read_en = 2'b10; ifa.read_addr = {5'd4, 5'd0};
      cycle();
      n_checks++;
      if (obs_node[0][23:12] !== 12'h123 || obs_val[0][1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bypass: got node=%h valid=%b, expected 123/1",
                  obs_node[0][23:12], obs_val[0][1]);
      end
      ifa.read_en = 2'b00; ifa.write_node = 12'h456;
      cycle();
      n_checks++;
      if (obs_node[0][23:12] !== 12'h123 || obs_val[0][1] !== 1'b1) begin
         n_fail++;
         $display("FAIL hold: got node=%h valid=%b, expected 123/1",
                  obs_node[0][23:12], obs_val[0][1]);
      end
      ifa.write = 1'b0; ifa.read_en = 2'b10;
      cycle();
      n_checks++;
      if (obs_node[0][23:12] !== 12'h456 || obs_val[0][1] !== 1'b1) begin
         n_fail++;
         $display("FAIL stored_after_hold: got node=%h valid=%b, expected 456/1",
                  obs_node[0][23:12], obs_val[0][1]);
      end
      idle_inputs();
   endtask

   task automatic test_clear();
      int busy_cycles;
      idle_inputs();
      for (int i = 0; i < 32; i++) begin
         ifa.write = 1'b1; ifa.write_addr = i[4:0]; ifa.write_node = 12'(i);
         cycle();
      end
      ifa.write = 1'b0; ifa.clear = 1'b1;
      cycle();
      ifa.clear = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 40 && obs_busy[0]; c++) begin
         busy_cycles++;
         ifa.write = (c == 3); ifa.write_addr = 5'd0; ifa.write_node = 12'hAAA;
         ifa.read_en = 2'b11;
         ifa.read_addr = {5'($urandom_range(31)), 5'($urandom_range(31))};
         cycle();
         n_checks++;
         if (obs_node[0] !== 24'h0 || obs_val[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL read_during_clear: got node=%h valid=%b, expected 0/0",
                     obs_node[0], obs_val[0]);
         end
      end
      n_checks++;
      if (busy_cycles != 32) begin
         n_fail++;
         $display("FAIL busy_length: got %0d cycles, expected 32", busy_cycles);
      end
      idle_inputs();
      for (int i = 0; i < 32; i += 2) begin
         ifa.read_en = 2'b11; ifa.read_addr = {5'(i + 1), 5'(i)};
         cycle();
         n_checks++;
         if (obs_node[0] !== 24'h0 || obs_val[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL after_clear addr%0d: got node=%h valid=%b, expected 0/0",
                     i, obs_node[0], obs_val[0]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_clear_corner();
      int busy_cycles;
      idle_inputs();
      ifa.clear = 1'b1; ifa.write = 1'b1; ifa.write_addr = 5'd31; ifa.write_node = 12'hFFF;
      cycle();
      ifa.write = 1'b0; ifa.clear = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 40 && obs_busy[0]; c++) begin
         busy_cycles++;
         ifa.clear = (c == 5);
         cycle();
      end
      ifa.clear = 1'b0;
      n_checks++;
      if (busy_cycles != 32) begin
         n_fail++;
         $display("FAIL reclear_busy_length: got %0d cycles, expected 32", busy_cycles);
      end
      ifa.read_en = 2'b01; ifa.read_addr = {5'd0, 5'd31};
      cycle();
      n_checks++;
      if (obs_node[0][11:0] !== 12'h000 || obs_val[0][0] !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_wipes_write: got node=%h valid=%b, expected 000/0",
                  obs_node[0][11:0], obs_val[0][0]);
      end
      idle_inputs();
      ifa.clear = 1'b1;
      cycle();
      ifa.clear = 1'b0;
      for (int c = 0; c < 10; c++) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      n_checks++;
      if (obs_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_aborts_clear: got busy=%b, expected 0", obs_busy[0]);
      end
      ifa.write = 1'b1; ifa.write_addr = 5'd30; ifa.write_node = 12'h0F0;
      cycle();
      ifa.write = 1'b0; ifa.read_en = 2'b11; ifa.read_addr = {5'd7, 5'd30};
      cycle();
      n_checks++;
      if (obs_node[0][11:0] !== 12'h0F0 || obs_val[0][0] !== 1'b1) begin
         n_fail++;
         $display("FAIL write_after_abort: got node=%h valid=%b, expected 0f0/1",
                  obs_node[0][11:0], obs_val[0][0]);
      end
      n_checks++;
      if (obs_node[0][23:12] !== 12'h000 || obs_val[0][1] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cleared_entry: got node=%h valid=%b, expected 000/0",
                  obs_node[0][23:12], obs_val[0][1]);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         ifa.write = ($urandom_range(99) < 50); ifa.write_addr = 5'($urandom_range(31));
         ifa.write_node = 12'($urandom()); ifa.read_en = 2'($urandom_range(3));
         ifa.read_addr = 10'($urandom()); ifa.clear = ($urandom_range(79) == 0);
         ifb.write = ($urandom_range(99) < 50); ifb.write_addr = 5'($urandom_range(31));
         ifb.write_node = 12'($urandom()); ifb.read_en = 2'($urandom_range(3));
         ifb.read_addr = 10'($urandom()); ifb.clear = ($urandom_range(59) == 0);
         reset = ($urandom_range(399) != 0);
         cycle();
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               n_checks++;
               if (obs_node[d][p*12 +: 12] !== e_node[d][p] || obs_val[d][p] !== e_val[d][p]) begin
                  n_fail++;
                  $display("FAIL random dut%0d p%0d cyc%0d: got node=%h valid=%b, expected %h/%b",
                           d, p, n, obs_node[d][p*12 +: 12], obs_val[d][p], e_node[d][p], e_val[d][p]);
               end
            end
            n_checks++;
            if (obs_busy[d] !== e_busy[d]) begin
               n_fail++;
               $display("FAIL random_busy dut%0d cyc%0d: got %b, expected %b",
                        d, n, obs_busy[d], e_busy[d]);
            end
         end
      end
      reset = 1'b1;
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      for (int d = 0; d < 2; d++) begin
         m_left[d] = 0;
         m_idx[d]  = 0;
      end
      @(negedge clk);
      test_reset();
      test_write_read();
      test_bypass();
      test_clear();
      test_clear_corner();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
